mem_arbiter: RTL

Arbitrates the single external memory bus between the CPU's instruction-fetch path and its data load/store path. The block sits between the core (fetch unit and decoder-driven data access) and the SDRAM/peripheral memory controller. It serialises one transaction at a time and issues it with a req/cack/ready handshake. It also prevents fetch starvation and bounds every transaction with a timeout.

---
 rtl/mem_arbiter_pkg.sv | 39 +++
 rtl/bus_timeout.sv | 56 +++++
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared encodings for the memory-bus arbiter: FSM state codes,
//               transaction owner codes, bus widths and the all-ones values
//               returned to a requester whose transaction was aborted.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // 2-bit state encoding: IDLE=0, ISSUE=1, RESP=2, DONE=3
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Which requester owns the transaction currently on the bus
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int          C_ADDR_W  = 20;
    localparam int          C_IDATA_W = 32;
    localparam int          C_DDATA_W = 16;

    // Data returned on a timed-out transaction
    localparam logic [31:0] C_ABORT_I = 32'hFFFF_FFFF;
    localparam logic [15:0] C_ABORT_D = 16'hFFFF;

    // Width of a counter that must be able to hold the value 'limit'
    function automatic int count_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/bus_timeout.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout
// Description : Loadable up-counter that flags when a bus transaction has
//               been outstanding for TIMEOUT cycles. TIMEOUT=0 disables the
//               expired flag entirely.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous reset, active-low
//               clear      - zero the counter (highest priority)
//               load       - load load_value into the counter
//               load_value - value for load
//               enable     - count one cycle
//               expired    - counter equals TIMEOUT (nonzero TIMEOUT only)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    // Saturates at all-ones so a disabled or ignored counter never wraps
    // back onto the limit value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_limit
            assign expired = (r_count == C_LIMIT);
        end else begin : g_no_limit
            assign expired = 1'b0;
        end
    endgenerate

endmodule : bus_timeout
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Serialises instruction-fetch and data load/store requests
//               onto the single external memory bus using a req/cack/ready
//               handshake. Data normally wins a tie; after STARVE_LIMIT
//               consecutive data grants with fetch waiting, fetch wins.
//               Every transaction is bounded by a TIMEOUT-cycle abort.
// Ports       : clk, rst (async, active-low)
//               i_req/i_addr -> i_done/i_data     fetch requester
//               d_req/d_we/d_addr/d_wdata -> d_done/d_rdata  data requester
//               m_req/m_we/m_instr/m_addr/m_wdata -> memory controller
//               m_cack/m_ready/m_rdata <- memory controller
//               err  - one-cycle pulse with done on a timed-out transaction
//               busy - high whenever the arbiter is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [C_ADDR_W-1:0]  i_addr,
    output logic                 i_done,
    output logic [C_IDATA_W-1:0] i_data,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [C_ADDR_W-1:0]  d_addr,
    input  logic [C_DDATA_W-1:0] d_wdata,
    output logic                 d_done,
    output logic [C_DDATA_W-1:0] d_rdata,
    output logic                 m_req,
    output logic                 m_we,
    output logic                 m_instr,
    output logic [C_ADDR_W-1:0]  m_addr,
    output logic [C_DDATA_W-1:0] m_wdata,
    input  logic                 m_cack,
    input  logic                 m_ready,
    input  logic [C_IDATA_W-1:0] m_rdata,
    output logic                 err,
    output logic                 busy
);

    localparam int                    C_STREAK_W   = count_width(STARVE_LIMIT);
    localparam logic [C_STREAK_W-1:0] C_STREAK_MAX = C_STREAK_W'(STARVE_LIMIT);

    arb_state_t            r_state;
    arb_state_t            w_state_nx;
    owner_t                r_owner;
    logic [C_STREAK_W-1:0] r_streak;

    logic w_grant;       // a requester is granted this cycle
    logic w_grant_d;     // ...and it is the data path
    logic w_capture;     // m_rdata is taken this cycle
    logic w_abort;       // transaction times out this cycle
    logic w_tmo_en;
    logic w_tmo_expired;

    assign w_tmo_en = (r_state == ST_ISSUE) || (r_state == ST_RESP);

    bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_grant),
        .load       (1'b0),
        .load_value ('0),
        .enable     (w_tmo_en),
        .expired    (w_tmo_expired)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode.
    // A completing handshake beats the timeout in the same cycle, but the
    // timeout beats a bare cack: moving to RESP past the limit would leave
    // the counter unable to ever match again.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_grant    = 1'b0;
        w_grant_d  = 1'b0;
        w_capture  = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    w_grant    = 1'b1;
                    w_grant_d  = d_req && !(i_req && (r_streak == C_STREAK_MAX));
                    w_state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_cack && m_ready) begin
                    w_capture  = 1'b1;
                    w_state_nx = ST_DONE;
                end else if (w_tmo_expired) begin
                    w_abort    = 1'b1;
                    w_state_nx = ST_DONE;
                end else if (m_cack) begin
                    w_state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_ready) begin
                    w_capture  = 1'b1;
                    w_state_nx = ST_DONE;
                end else if (w_tmo_expired) begin
                    w_abort    = 1'b1;
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the next state so every output
    // changes on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= OWN_I;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_instr <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            i_data  <= '0;
            d_rdata <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            m_req  <= (w_state_nx == ST_ISSUE);
            busy   <= (w_state_nx != ST_IDLE);
            err    <= w_abort;
            // DONE is only reachable from ISSUE/RESP, where r_owner is valid
            i_done <= (w_state_nx == ST_DONE) && (r_owner == OWN_I);
            d_done <= (w_state_nx == ST_DONE) && (r_owner == OWN_D);

            if (w_grant) begin
                r_owner <= w_grant_d ? OWN_D : OWN_I;
                m_instr <= !w_grant_d;
                m_addr  <= w_grant_d ? d_addr : i_addr;
                m_we    <= w_grant_d && d_we;
                m_wdata <= w_grant_d ? d_wdata : '0;
            end

            if (w_capture) begin
                if (r_owner == OWN_I) begin
                    i_data <= m_rdata;
                end else begin
                    d_rdata <= m_rdata[C_DDATA_W-1:0];
                end
            end else if (w_abort) begin
                if (r_owner == OWN_I) begin
                    i_data <= C_ABORT_I;
                end else begin
                    d_rdata <= C_ABORT_D;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Starvation streak: counts data grants won while fetch was waiting.
    // Only IDLE cycles matter; the value is held across a transaction so
    // back-to-back requests keep accumulating.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak <= '0;
        end else if (r_state == ST_IDLE) begin
            if (!i_req) begin
                r_streak <= '0;
            end else if (w_grant && !w_grant_d) begin
                r_streak <= '0;
            end else if (w_grant_d && (r_streak != C_STREAK_MAX)) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end

endmodule : mem_arbiter
`default_nettype wire
